// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, state encoding and signed limits
// for the Booth multiplier accumulator stage.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  function automatic int pw_f(input int size);
    return 2 ** (size + 1);
  endfunction

  function automatic int acc_w_f(input int size, input int guard);
    return pw_f(size) + guard;
  endfunction

  function automatic logic [63:0] smax_f(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin_f(input int w);
    return ~smax_f(w);
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: signed W-bit adder with overflow flag; clamps on
// overflow when BOOTH_ACCUM_SAT_EN is defined, otherwise wraps.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) &&
               (raw[W-1] != a[W-1]);

`ifdef BOOTH_ACCUM_SAT_EN
  localparam logic [63:0] MAXV = smax_f(W);
  localparam logic [63:0] MINV = smin_f(W);

  assign sum = !ovf    ? raw :
               a[W-1]  ? MINV[W-1:0] :
                         MAXV[W-1:0];
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/booth_accum.sv
// booth_accum: dot-product accumulator behind the Booth multiplier.
// Optional clamp on overflow via BOOTH_ACCUM_SAT_EN.
module booth_accum
  import booth_pkg::*;
#(
  parameter  int SIZE  = 3,
  parameter  int LEN_W = 4,
  parameter  int GUARD = 4,
  localparam int PW    = pw_f(SIZE),
  localparam int ACC_W = acc_w_f(SIZE, GUARD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic [PW-1:0]    prod_in,
  input  logic             prod_done,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf,
  output logic             err_drop
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  state_t           nxt;
  logic             done_q;
  logic             take;
  logic             hs;
  logic             start;
  logic             add;
  logic             add_ovf;
  logic             pend_full;
  logic [PW-1:0]    pend;
  logic [PW-1:0]    src;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] ext_in;
  logic [ACC_W-1:0] ext_src;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] tgt;
  logic [LEN_W-1:0] len_eff;

  assign take    = prod_done & ~done_q;
  assign hs      = acc_valid & acc_ready;
  assign len_eff = (len == '0) ? ONE : len;
  assign ext_in  = {{GUARD{prod_in[PW-1]}}, prod_in};
  assign ext_src = {{GUARD{src[PW-1]}}, src};
  assign acc_out = acc;

  booth_sat_add #(
    .W (ACC_W)
  ) u_add (
    .a   (acc),
    .b   (ext_in),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt   = state;
    start = 1'b0;
    add   = 1'b0;
    src   = prod_in;
    unique case (state)
      IDLE:  start = take;
      ACCUM: begin
        if (take) begin
          add = 1'b1;
          if (cnt + ONE == tgt) nxt = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          if (pend_full) begin
            start = 1'b1;
            src   = pend;
          end else if (take) begin
            start = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
    if (start) nxt = (len_eff == ONE) ? HOLD : ACCUM;
    if (clear) begin
      nxt   = IDLE;
      start = 1'b0;
      add   = 1'b0;
    end
  end

  always_comb begin
    acc_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      tgt       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      ovf       <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      done_q <= prod_done;
      if (clear) begin
        acc       <= '0;
        cnt       <= '0;
        pend_full <= 1'b0;
        ovf       <= 1'b0;
        err_drop  <= 1'b0;
      end else begin
        if (start) begin
          acc <= ext_src;
          cnt <= ONE;
          tgt <= len_eff;
          ovf <= 1'b0;
        end
        if (add) begin
          acc <= sum;
          cnt <= cnt + ONE;
          if (add_ovf) ovf <= 1'b1;
        end
        // slot refills on the same cycle it is drained into a new sum
        if (state == HOLD) begin
          if (hs) begin
            if (pend_full) begin
              pend_full <= take;
              pend      <= prod_in;
            end
          end else if (take) begin
            if (pend_full) begin
              err_drop <= 1'b1;
            end else begin
              pend      <= prod_in;
              pend_full <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_accum.sv
// tb_booth_accum: scoreboard bench for booth_accum with directed
// cases and randomized dot products against a reference model.
module tb_booth_accum;

  localparam int SIZE  = 3;
  localparam int LEN_W = 4;
  localparam int GUARD = 2;
  localparam int PW    = 16;
  localparam int ACC_W = 18;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;
  localparam longint MOD  = 262144;

  typedef struct {
    longint v;
    bit     ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [PW-1:0]    prod_in = '0;
  logic             prod_done = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             busy;
  logic             ovf;
  logic             err_drop;

  bit rnd_ready = 1'b0;
  bit rnd_bit   = 1'b0;
  bit fix_ready = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   outst = 0;
  int   extra = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  assign acc_ready = rnd_ready ? rnd_bit : fix_ready;

  booth_accum #(
    .SIZE  (SIZE),
    .LEN_W (LEN_W),
    .GUARD (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .len       (len),
    .prod_in   (prod_in),
    .prod_done (prod_done),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .busy      (busy),
    .ovf       (ovf),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input longint act,
                              input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // one signed ACC_W-bit add as the design should perform it
  function automatic void model_add(inout longint acc,
                                    inout bit ov,
                                    input longint p);
    longint s;
    s = acc + p;
    if (s > MAXV || s < MINV) begin
      ov = 1'b1;
`ifdef BOOTH_ACCUM_SAT_EN
      s = (s > MAXV) ? MAXV : MINV;
`else
      s = (s > MAXV) ? s - MOD : s + MOD;
`endif
    end
    acc = s;
  endfunction

  function automatic void push(input longint v, input bit ov);
    exp_t e;
    e.v  = v;
    e.ov = ov;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take_edge(input longint v);
    prod_in   = PW'(v);
    prod_done = 1'b1;
    tick();
    prod_done = 1'b0;
  endtask

  task automatic pulse(input longint v);
    take_edge(v);
    tick();
  endtask

  // monitor: every completed handshake pops one expected result
  always @(negedge clk) begin
    if (rst_n && !clear && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d expected none",
                 $signed(acc_out));
      end else begin
        e_mon = exp_q.pop_front();
        chk("acc_out", $signed(acc_out), e_mon.v);
        chk("ovf", longint'(ovf), longint'(e_mon.ov));
      end
      if (outst > 0) outst--;
      extra = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint macc;
    bit     mov;
    longint p;
    logic [15:0] r16;
    int     nl;
    int     n;
    int     w;
    bit     stuck;

    repeat (3) tick();
    chk("rst_valid", longint'(acc_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_acc", $signed(acc_out), 0);
    chk("rst_flags", longint'({ovf, err_drop}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", longint'(busy), 0);

    // three-term sum with latency check
    len = 4'd3;
    fix_ready = 1'b0;
    push(94, 1'b0);
    pulse(6);
    pulse(-12);
    chk("pre_valid", longint'(acc_valid), 0);
    take_edge(100);
    chk("lat_valid", longint'(acc_valid), 1);
    tick();
    fix_ready = 1'b1;
    tick();
    chk("post_hs_valid", longint'(acc_valid), 0);
    chk("post_hs_busy", longint'(busy), 0);

    // held-high done counts once
    len = 4'd1;
    push(7, 1'b0);
    prod_in   = 16'd7;
    prod_done = 1'b1;
    repeat (5) tick();
    prod_done = 1'b0;
    repeat (3) tick();
    chk("held_valid", longint'(acc_valid), 0);

    // pending slot and drop
    fix_ready = 1'b0;
    pulse(5);
    pulse(9);
    chk("slot_acc", $signed(acc_out), 5);
    chk("slot_drop", longint'(err_drop), 0);
    pulse(11);
    chk("drop_flag", longint'(err_drop), 1);
    push(5, 1'b0);
    push(9, 1'b0);
    fix_ready = 1'b1;
    repeat (3) tick();
    chk("slot_empty", longint'(acc_valid), 0);
    chk("drop_sticky", longint'(err_drop), 1);

    // overflow, continuing after it
    len = 4'd6;
`ifdef BOOTH_ACCUM_SAT_EN
    push(130071, 1'b1);
`else
    push(-113144, 1'b1);
`endif
    repeat (5) pulse(30000);
    pulse(-1000);
    repeat (2) tick();

    // clear mid-sum
    len = 4'd4;
    pulse(1000);
    pulse(2000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", longint'(busy), 0);
    chk("clr_valid", longint'(acc_valid), 0);
    chk("clr_drop", longint'(err_drop), 0);
    len = 4'd2;
    push(-74, 1'b0);
    pulse(-77);
    pulse(3);
    repeat (2) tick();

    // asynchronous reset while holding a result
    len = 4'd1;
    fix_ready = 1'b0;
    pulse(55);
    pulse(66);
    pulse(77);
    chk("pre_rst_drop", longint'(err_drop), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", longint'(acc_valid), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_acc", $signed(acc_out), 0);
    chk("arst_flags", longint'({ovf, err_drop}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    fix_ready = 1'b1;
    repeat (3) tick();
    chk("arst_noslot", longint'(acc_valid), 0);

    // randomized dot products under random backpressure
    outst = 0;
    extra = 0;
    rnd_ready = 1'b1;
    stuck = 1'b0;
    for (int s = 0; s < 40 && !stuck; s++) begin
      nl = $urandom_range(0, 15);
      n  = (nl == 0) ? 1 : nl;
      macc = 0;
      mov  = 1'b0;
      for (int k = 0; k < n && !stuck; k++) begin
        w = 0;
        while (!(outst == 0 || extra == 0) && !stuck) begin
          tick();
          w++;
          if (w > 500) begin
            stuck = 1'b1;
            n_cmp++;
            n_bad++;
            $display("FAIL pace_timeout: got %0d expected 0", outst);
          end
        end
        if (!stuck) begin
          r16 = 16'($urandom);
          unique case (s % 4)
            0: p = 20000 + longint'($urandom_range(0, 12767));
            1: p = -20000 - longint'($urandom_range(0, 12768));
            default: p = longint'($signed(r16));
          endcase
          if (k == 0) begin
            len  = LEN_W'(nl);
            macc = p;
          end else begin
            model_add(macc, mov, p);
          end
          if (outst > 0) extra = 1;
          if (k == n - 1) begin
            push(macc, mov);
            outst++;
          end
          pulse(p);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    end

    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      tick();
      w++;
    end
    chk("drain_left", longint'(exp_q.size()), 0);
    rnd_ready = 1'b0;
    repeat (3) tick();
    chk("end_busy", longint'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
